// File: rtl/aib_sr_rx.sv
`default_nettype none
// ============================================================================
// Module   : aib_sr_rx
// Brief    : AIB sideband shift-register receiver. Deserializes srd/srl frames,
//            checks frame length, tracks lock and drops it on error or stall.
// Revision : 1.0 - initial release
// ============================================================================
module aib_sr_rx #(
    parameter int SR_LENGTH   = 81,
    parameter int CNT_W       = 7,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 1023,
    parameter int TO_W        = 10
) (
    input  logic                 sr_clk_in,
    input  logic                 sr_rst,
    input  logic                 sr_en,
    input  logic                 sr_data_in,
    input  logic                 sr_load_in,
    output logic [SR_LENGTH-1:0] sr_data_to_core,
    output logic                 sr_frame_vld,
    output logic                 sr_frame_err,
    output logic                 sr_lock,
    output logic [CNT_W-1:0]     sr_bit_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(SR_LENGTH);
    localparam logic [CNT_W-1:0] c_CNT_OVR  = CNT_W'(SR_LENGTH + 1);
    localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_GOOD_MAX = 4'(LOCK_FRAMES);

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RECV  = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_load_q;
    logic [SR_LENGTH-1:0]   r_shreg;
    logic [SR_LENGTH-1:0]   r_data;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [3:0]             r_good_cnt;
    logic                   r_vld;
    logic                   r_err;
    logic                   r_lock;

    logic                   w_load_edge;
    logic [3:0]             w_good_inc;

    // Previous-load resets high so a strobe already asserted out of reset is not a boundary.
    assign w_load_edge = sr_load_in & ~r_load_q;
    assign w_good_inc  = (r_good_cnt == c_GOOD_MAX) ? r_good_cnt : r_good_cnt + 4'd1;

    always_ff @(posedge sr_clk_in or posedge sr_rst) begin
        if (sr_rst) begin
            r_state    <= ST_ALIGN;
            r_load_q   <= 1'b1;
            r_shreg    <= '0;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_good_cnt <= '0;
            r_vld      <= 1'b0;
            r_err      <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_load_q <= sr_load_in;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
            if (!sr_en) begin
                r_state    <= ST_ALIGN;
                r_bit_cnt  <= '0;
                r_to_cnt   <= '0;
                r_good_cnt <= '0;
                r_lock     <= 1'b0;
            end else if (r_state == ST_ALIGN) begin
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                if (w_load_edge) begin
                    r_state <= ST_RECV;
                end
            end else if (w_load_edge) begin
                if (r_bit_cnt == c_CNT_FULL) begin
                    r_data     <= r_shreg;
                    r_vld      <= 1'b1;
                    r_good_cnt <= w_good_inc;
                    r_lock     <= (w_good_inc == c_GOOD_MAX);
                end else begin
                    r_err      <= 1'b1;
                    r_good_cnt <= '0;
                    r_lock     <= 1'b0;
                end
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
            end else if (r_to_cnt == c_TO_LAST) begin
                // Stalled stream: this cycle would be the TIMEOUT-th without a boundary.
                r_err      <= 1'b1;
                r_lock     <= 1'b0;
                r_good_cnt <= '0;
                r_state    <= ST_ALIGN;
                r_bit_cnt  <= '0;
                r_to_cnt   <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
                if (!sr_load_in) begin
                    r_shreg <= {r_shreg[SR_LENGTH-2:0], sr_data_in};
                    if (r_bit_cnt != c_CNT_OVR) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign sr_data_to_core = r_data;
    assign sr_frame_vld    = r_vld;
    assign sr_frame_err    = r_err;
    assign sr_lock         = r_lock;
    assign sr_bit_cnt      = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aib_sr_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_aib_sr_rx
// Brief    : Directed bench for aib_sr_rx with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aib_sr_rx;

    localparam int SR_LENGTH   = 81;
    localparam int CNT_W       = 7;
    localparam int LOCK_FRAMES = 2;
    localparam int TIMEOUT     = 1023;
    localparam int TO_W        = 10;

    localparam logic [SR_LENGTH-1:0] c_W1 = 81'h1_2345_6789_ABCD_EF01_2345;
    localparam logic [SR_LENGTH-1:0] c_W2 = 81'h0_F0F0_1234_5678_9ABC_DEF0;

    logic                 clk;
    logic                 sr_rst;
    logic                 sr_en;
    logic                 sr_data_in;
    logic                 sr_load_in;
    logic [SR_LENGTH-1:0] sr_data_to_core;
    logic                 sr_frame_vld;
    logic                 sr_frame_err;
    logic                 sr_lock;
    logic [CNT_W-1:0]     sr_bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: received bits kept by position, counters as plain integers.
    logic                 m_bits [SR_LENGTH];
    logic [SR_LENGTH-1:0] m_data;
    logic                 m_vld, m_err, m_lock, m_prev, m_aligned;
    int                   m_cnt, m_since, m_good;

    aib_sr_rx #(
        .SR_LENGTH  (SR_LENGTH),
        .CNT_W      (CNT_W),
        .LOCK_FRAMES(LOCK_FRAMES),
        .TIMEOUT    (TIMEOUT),
        .TO_W       (TO_W)
    ) u_dut (
        .sr_clk_in      (clk),
        .sr_rst         (sr_rst),
        .sr_en          (sr_en),
        .sr_data_in     (sr_data_in),
        .sr_load_in     (sr_load_in),
        .sr_data_to_core(sr_data_to_core),
        .sr_frame_vld   (sr_frame_vld),
        .sr_frame_err   (sr_frame_err),
        .sr_lock        (sr_lock),
        .sr_bit_cnt     (sr_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_data    = '0;
        m_vld     = 1'b0;
        m_err     = 1'b0;
        m_lock    = 1'b0;
        m_prev    = 1'b1;
        m_aligned = 1'b0;
        m_cnt     = 0;
        m_since   = 0;
        m_good    = 0;
    endtask

    task automatic model_update(input logic d, input logic l, input logic e);
        logic edge_seen;
        edge_seen = l && !m_prev;
        m_vld = 1'b0;
        m_err = 1'b0;
        if (!e) begin
            m_aligned = 1'b0;
            m_cnt     = 0;
            m_since   = 0;
            m_good    = 0;
            m_lock    = 1'b0;
        end else if (!m_aligned) begin
            m_cnt   = 0;
            m_since = 0;
            if (edge_seen) m_aligned = 1'b1;
        end else if (edge_seen) begin
            if (m_cnt == SR_LENGTH) begin
                for (int i = 0; i < SR_LENGTH; i++) m_data[SR_LENGTH-1-i] = m_bits[i];
                m_vld = 1'b1;
                if (m_good < LOCK_FRAMES) m_good = m_good + 1;
                m_lock = (m_good == LOCK_FRAMES);
            end else begin
                m_err  = 1'b1;
                m_good = 0;
                m_lock = 1'b0;
            end
            m_cnt   = 0;
            m_since = 0;
        end else begin
            m_since = m_since + 1;
            if (m_since == TIMEOUT) begin
                m_err     = 1'b1;
                m_lock    = 1'b0;
                m_good    = 0;
                m_aligned = 1'b0;
                m_cnt     = 0;
                m_since   = 0;
            end else if (!l) begin
                if (m_cnt < SR_LENGTH) m_bits[m_cnt] = d;
                if (m_cnt < SR_LENGTH + 1) m_cnt = m_cnt + 1;
            end
        end
        m_prev = l;
    endtask

    task automatic step(input logic d, input logic l);
        sr_data_in = d;
        sr_load_in = l;
        @(posedge clk);
        if (sr_rst) model_reset();
        else        model_update(d, l, sr_en);
        #1;
    endtask

    task automatic send_bits(input logic [SR_LENGTH-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            step((i < SR_LENGTH) ? w[SR_LENGTH-1-i] : 1'b0, 1'b0);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        n_checks++;
        if (sr_data_to_core !== m_data || sr_frame_vld !== m_vld || sr_frame_err !== m_err ||
            sr_lock !== m_lock || sr_bit_cnt !== CNT_W'(m_cnt)) begin
            n_fail++;
            $display("FAIL model t=%0t: got data=%0h vld=%b err=%b lock=%b cnt=%0d expected data=%0h vld=%b err=%b lock=%b cnt=%0d",
                     $time, sr_data_to_core, sr_frame_vld, sr_frame_err, sr_lock, sr_bit_cnt,
                     m_data, m_vld, m_err, m_lock, m_cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sr_rst     = 1'b1;
        sr_en      = 1'b1;
        sr_data_in = 1'b0;
        sr_load_in = 1'b1;
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_data", sr_data_to_core, '0);
        chk("reset_flags", {sr_frame_vld, sr_frame_err, sr_lock}, 3'b000);
        chk("reset_cnt", sr_bit_cnt, 0);
        sr_rst = 1'b0;

        // Load high out of reset is not a boundary; data while aligning is ignored.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("align_ignores_data", sr_bit_cnt, 0);
        step(1'b0, 1'b1);
        chk("align_edge_no_pulse", {sr_frame_vld, sr_frame_err, sr_bit_cnt}, 0);

        send_bits(c_W1, 81);
        chk("full_count", sr_bit_cnt, 81);
        step(1'b0, 1'b1);
        chk("frame1_vld", {sr_frame_vld, sr_frame_err, sr_lock}, 3'b100);
        chk("frame1_data", sr_data_to_core, c_W1);
        send_bits(c_W1, 81);
        step(1'b0, 1'b1);
        chk("frame2_lock", {sr_frame_vld, sr_lock}, 2'b11);

        // Short frame while locked.
        send_bits(c_W2, 80);
        step(1'b0, 1'b1);
        chk("short_err", {sr_frame_vld, sr_frame_err, sr_lock}, 3'b010);
        chk("short_data_held", sr_data_to_core, c_W1);
        send_bits(c_W2, 81);
        step(1'b0, 1'b1);
        send_bits(c_W2, 81);
        step(1'b0, 1'b1);
        chk("relock", {sr_frame_vld, sr_lock}, 2'b11);
        chk("relock_data", sr_data_to_core, c_W2);

        // Overrun frame.
        send_bits(c_W1, 82);
        chk("overrun_sat", sr_bit_cnt, 82);
        step(1'b0, 1'b1);
        chk("overrun_err", {sr_frame_vld, sr_frame_err, sr_lock}, 3'b010);
        send_bits(c_W1, 81);
        step(1'b0, 1'b1);
        chk("after_overrun", {sr_frame_vld, sr_lock}, 2'b10);

        // Load held high for three cycles.
        send_bits(c_W2, 81);
        step(1'b0, 1'b1);
        chk("held_vld", {sr_frame_vld, sr_lock}, 2'b11);
        step(1'b1, 1'b1);
        chk("held_no_shift", {sr_frame_vld, sr_bit_cnt}, 0);
        step(1'b1, 1'b1);
        send_bits(c_W1, 81);
        step(1'b0, 1'b1);
        chk("after_held", sr_data_to_core, c_W1);

        // Stalled stream times out on the 1023rd cycle.
        repeat (TIMEOUT - 1) step(1'b0, 1'b0);
        chk("pre_timeout", {sr_frame_err, sr_lock}, 2'b01);
        step(1'b0, 1'b0);
        chk("timeout_err", {sr_frame_err, sr_lock, sr_bit_cnt}, {2'b10, 7'd0});

        // Boundary landing exactly on the timeout cycle wins.
        step(1'b0, 1'b1);
        repeat (941) step(1'b1, 1'b1);
        send_bits(c_W2, 81);
        step(1'b0, 1'b1);
        chk("edge_at_timeout", {sr_frame_vld, sr_frame_err}, 2'b10);
        chk("edge_at_timeout_data", sr_data_to_core, c_W2);

        // Disable drops lock, keeps data, needs a new boundary.
        sr_en = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        chk("disabled", {sr_lock, sr_bit_cnt}, 0);
        chk("disabled_data", sr_data_to_core, c_W2);
        sr_en = 1'b1;
        repeat (5) step(1'b1, 1'b0);
        chk("reenable_align", sr_bit_cnt, 0);
        step(1'b0, 1'b1);
        send_bits(c_W1, 81);
        step(1'b0, 1'b1);
        chk("reenable_frame", sr_data_to_core, c_W1);

        // Reset mid-frame.
        send_bits(c_W2, 40);
        chk("mid_cnt", sr_bit_cnt, 40);
        sr_rst = 1'b1;
        #1;
        chk("async_rst", {sr_data_to_core, sr_frame_vld, sr_frame_err, sr_lock, sr_bit_cnt}, 0);
        model_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        sr_rst = 1'b0;
        send_bits(c_W2, 20);
        chk("post_rst_ignore", sr_bit_cnt, 0);
        step(1'b0, 1'b1);
        send_bits(c_W2, 81);
        step(1'b0, 1'b1);
        chk("post_rst_frame", {sr_frame_vld, sr_lock}, 2'b10);
        chk("post_rst_data", sr_data_to_core, c_W2);

        repeat (2) step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
